// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: RV32I load/store funct3
// codes and the responder FSM state encoding.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

endpackage

// File: rtl/dmem_align.sv
// Lane steering for byte/half/word accesses: store byte-enables and data
// replication, load lane extraction with sign/zero extension, and error detect.
module dmem_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        err
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        bad_f3;
    logic        misalign;

    always_comb begin
        rbyte    = rword[{addr_lo, 3'b000} +: 8];
        rhalf    = addr_lo[1] ? rword[31:16] : rword[15:0];
        bad_f3   = 1'b0;
        misalign = 1'b0;
        be       = 4'b0000;
        wword    = 32'h0;
        rdata    = 32'h0;
        case (funct3)
            F3_B: begin
                be    = 4'b0001 << addr_lo;
                wword = {4{wdata[7:0]}};
                rdata = {{24{rbyte[7]}}, rbyte};
            end
            F3_H: begin
                misalign = addr_lo[0];
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                rdata    = {{16{rhalf[15]}}, rhalf};
            end
            F3_W: begin
                misalign = |addr_lo;
                be       = 4'b1111;
                wword    = wdata;
                rdata    = rword;
            end
            // Unsigned variants exist only for loads.
            F3_BU: begin
                bad_f3 = we;
                rdata  = {24'h0, rbyte};
            end
            F3_HU: begin
                bad_f3   = we;
                misalign = addr_lo[0];
                rdata    = {16'h0, rhalf};
            end
            default: bad_f3 = 1'b1;
        endcase
        err = bad_f3 | misalign;
        if (err) begin
            be    = 4'b0000;
            rdata = 32'h0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data memory for the MEM stage: one request at a time over
// valid/ready, single-cycle response strobe WAIT_CYC cycles after accept.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int         NUM_LANES = DATA_W / 8;
    localparam int         WORDS     = 2 ** (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT  = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef struct packed {
        logic              we;
        logic [2:0]        funct3;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

    dmem_state_e state, state_nxt;
    logic [3:0]  cnt;
    logic        accept;
    logic        enter_resp;
    dmem_req_t   req_in, req_q, cur;

    logic [NUM_LANES-1:0][7:0] mem [WORDS];
    logic [ADDR_W-3:0]         word_idx;
    logic [DATA_W-1:0]         rword;
    logic [3:0]                a_be;
    logic [DATA_W-1:0]         a_wword;
    logic [DATA_W-1:0]         a_rdata;
    logic                      a_err;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (WAIT_CYC > 0) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. RESP always exits to IDLE, so a next state of RESP marks entry.
    always_comb begin
        req_ready  = (state == IDLE) && !reset;
        accept     = req_valid && req_ready;
        enter_resp = (state_nxt == RESP) && (state != RESP) && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset)                        cnt <= 4'd0;
        else if (accept)                  cnt <= CNT_INIT;
        else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    always_comb begin
        req_in = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
    end

    always_ff @(posedge clk) begin
        if (accept) req_q <= req_in;
    end

    // With no wait cycles RESP is entered on the accept edge itself, before
    // the capture registers hold the request, so use the live inputs then.
    always_comb begin
        cur      = (state == IDLE) ? req_in : req_q;
        word_idx = cur.addr[ADDR_W-1:2];
        rword    = mem[word_idx];
    end

    dmem_align u_align (
        .we      (cur.we),
        .funct3  (cur.funct3),
        .addr_lo (cur.addr[1:0]),
        .wdata   (cur.wdata),
        .rword   (rword),
        .be      (a_be),
        .wword   (a_wword),
        .rdata   (a_rdata),
        .err     (a_err)
    );

    always_ff @(posedge clk) begin
        if (enter_resp && cur.we && !a_err) begin
            for (int l = 0; l < NUM_LANES; l++)
                if (a_be[l]) mem[word_idx][l] <= a_wword[l*8 +: 8];
        end
    end

    // Response registers load on RESP entry so they line up with the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= enter_resp;
            resp_err   <= enter_resp && a_err;
            resp_rdata <= (enter_resp && !cur.we && !a_err) ? a_rdata : '0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a byte-array
// reference model; a second instance covers the zero-wait configuration.
module tb_data_mem_responder;

    localparam int W = 2;

    logic        clk, reset;
    logic        req_valid, req_valid0;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;

    int nvec = 0;
    int nmis = 0;

    logic [7:0] ref_mem [512];

    data_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    data_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
        .resp_err(resp_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: memory as a flat byte array, accesses by size and alignment.
    task automatic ref_access(input logic we, input logic [2:0] f3, input logic [8:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int          size;
        logic [31:0] v, mask;
        bit          legal;
        rd    = 32'h0;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = 1 << f3[1:0];
        er    = !legal || ((int'(a) % size) != 0);
        if (er) return;
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8*i));
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
            if (!f3[2] && v[8*size-1]) v = v | ~mask;
            rd = v;
        end
    endtask

    // Drives one request on the WAIT_CYC=2 instance and collects its response.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output logic rv_after);
        int n;
        rd = '0; er = 1'b0; lat = -1; rv_after = 1'b0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = 9'($urandom);
        req_wdata  = $urandom;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = n; rd = resp_rdata; er = resp_err;
                @(negedge clk);
                rv_after = resp_valid;
                break;
            end
        end
        if (lat < 0) begin
            nvec++; nmis++;
            $display("FAIL issue_timeout: no resp_valid within 40 cycles, addr=%h", a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++; if (req_ready !== 1'b0) begin nmis++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        nvec++; if (resp_valid !== 1'b0) begin nmis++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
        nvec++; if (resp_rdata !== 32'h0) begin nmis++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        nvec++; if (resp_err !== 1'b0) begin nmis++; $display("FAIL reset_err: got %b want 0", resp_err); end
        nvec++; if (req_ready0 !== 1'b0) begin nmis++; $display("FAIL reset_ready0: got %b want 0", req_ready0); end
        reset = 1'b0;
        @(negedge clk);
        nvec++; if (req_ready !== 1'b1) begin nmis++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
        nvec++; if (resp_valid !== 1'b0) begin nmis++; $display("FAIL post_reset_valid: got %b want 0", resp_valid); end
    endtask

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [8:0]  addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    task automatic test_directed();
        vec_t        tbl [17];
        logic [31:0] rd, mrd;
        logic        er, mer, rv_after;
        int          lat;
        tbl = '{
            '{1'b1, 3'd2, 9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0},
            '{1'b0, 3'd2, 9'h010, 32'h00000000, 32'hDEADBEEF, 1'b0},
            '{1'b0, 3'd0, 9'h013, 32'h00000000, 32'hFFFFFFDE, 1'b0},
            '{1'b0, 3'd4, 9'h013, 32'h00000000, 32'h000000DE, 1'b0},
            '{1'b0, 3'd1, 9'h012, 32'h00000000, 32'hFFFFDEAD, 1'b0},
            '{1'b0, 3'd5, 9'h010, 32'h00000000, 32'h0000BEEF, 1'b0},
            '{1'b1, 3'd1, 9'h012, 32'h55551234, 32'h00000000, 1'b0},
            '{1'b0, 3'd2, 9'h010, 32'h00000000, 32'h1234BEEF, 1'b0},
            '{1'b1, 3'd0, 9'h011, 32'hABCDEF77, 32'h00000000, 1'b0},
            '{1'b0, 3'd2, 9'h010, 32'h00000000, 32'h123477EF, 1'b0},
            '{1'b0, 3'd2, 9'h011, 32'h00000000, 32'h00000000, 1'b1},
            '{1'b1, 3'd2, 9'h012, 32'hFFFFFFFF, 32'h00000000, 1'b1},
            '{1'b1, 3'd1, 9'h011, 32'hFFFFFFFF, 32'h00000000, 1'b1},
            '{1'b0, 3'd1, 9'h013, 32'h00000000, 32'h00000000, 1'b1},
            '{1'b0, 3'd3, 9'h010, 32'h00000000, 32'h00000000, 1'b1},
            '{1'b1, 3'd4, 9'h010, 32'hFFFFFFFF, 32'h00000000, 1'b1},
            '{1'b0, 3'd2, 9'h010, 32'h00000000, 32'h123477EF, 1'b0}
        };
        for (int i = 0; i < 17; i++) begin
            ref_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, mrd, mer);
            issue(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, rd, er, lat, rv_after);
            nvec++; if (rd !== tbl[i].rd) begin nmis++; $display("FAIL dir%0d_rdata: got %h want %h", i, rd, tbl[i].rd); end
            nvec++; if (er !== tbl[i].er) begin nmis++; $display("FAIL dir%0d_err: got %b want %b", i, er, tbl[i].er); end
            nvec++; if (lat !== W + 1) begin nmis++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, W + 1); end
            nvec++; if (rv_after !== 1'b0) begin nmis++; $display("FAIL dir%0d_single_pulse: got %b want 0", i, rv_after); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, wd;
        logic        er, mer, rv_after, we;
        logic [2:0]  f3;
        logic [8:0]  a;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            a  = 9'h080 + 9'(4 * i);
            ref_access(1'b1, 3'd2, a, wd, mrd, mer);
            issue(1'b1, 3'd2, a, wd, rd, er, lat, rv_after);
            nvec++; if (er !== 1'b0) begin nmis++; $display("FAIL rnd_init_err: addr %h got %b want 0", a, er); end
        end
        for (int i = 0; i < 50; i++) begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = 9'h080 + 9'($urandom_range(0, 63));
            wd = $urandom;
            ref_access(we, f3, a, wd, mrd, mer);
            issue(we, f3, a, wd, rd, er, lat, rv_after);
            nvec++; if (rd !== mrd) begin nmis++; $display("FAIL rnd%0d_rdata: we=%b f3=%0d addr=%h got %h want %h", i, we, f3, a, rd, mrd); end
            nvec++; if (er !== mer) begin nmis++; $display("FAIL rnd%0d_err: we=%b f3=%0d addr=%h got %b want %b", i, we, f3, a, er, mer); end
            nvec++; if (lat !== W + 1) begin nmis++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, W + 1); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] mrd;
        logic        mer;
        bit          exp_ready, exp_rv;
        ref_access(1'b0, 3'd2, 9'h010, 32'h0, mrd, mer);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 9'h010; req_wdata = 32'h0;
        for (int c = 0; c < 16; c++) begin
            exp_ready = (c % (W + 2)) == 0;
            exp_rv    = (c % (W + 2)) == W + 1;
            nvec++; if (req_ready !== exp_ready) begin nmis++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, req_ready, exp_ready); end
            nvec++; if (resp_valid !== exp_rv) begin nmis++; $display("FAIL b2b_valid c=%0d: got %b want %b", c, resp_valid, exp_rv); end
            if (exp_rv) begin
                nvec++; if (resp_rdata !== mrd) begin nmis++; $display("FAIL b2b_rdata c=%0d: got %h want %h", c, resp_rdata, mrd); end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_wait0();
        @(negedge clk);
        req_valid0 = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 9'h040; req_wdata = 32'h5A5A1234;
        for (int c = 0; c < 8; c++) begin
            nvec++; if (req_ready0 !== (c % 2 == 0)) begin nmis++; $display("FAIL w0_ready c=%0d: got %b want %b", c, req_ready0, c % 2 == 0); end
            nvec++; if (resp_valid0 !== (c % 2 == 1)) begin nmis++; $display("FAIL w0_valid c=%0d: got %b want %b", c, resp_valid0, c % 2 == 1); end
            if (c % 2 == 1) begin
                nvec++;
                if (resp_rdata0 !== ((c == 1) ? 32'h0 : 32'h5A5A1234) || resp_err0 !== 1'b0) begin
                    nmis++; $display("FAIL w0_data c=%0d: got %h/%b want %h/0", c, resp_rdata0, resp_err0, (c == 1) ? 32'h0 : 32'h5A5A1234);
                end
            end
            if (c == 1) req_we = 1'b0;
            @(negedge clk);
        end
        req_valid0 = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, mrd;
        logic        er, mer, rv_after, seen;
        int          lat;
        ref_access(1'b1, 3'd2, 9'h020, 32'h0, mrd, mer);
        issue(1'b1, 3'd2, 9'h020, 32'h0, rd, er, lat, rv_after);
        // Store aborted by reset during WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 9'h020; req_wdata = 32'hAAAAAAAA;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin @(negedge clk); seen = seen | resp_valid; end
        nvec++; if (seen !== 1'b0) begin nmis++; $display("FAIL abort_no_resp: got %b want 0", seen); end
        nvec++; if (req_ready !== 1'b1) begin nmis++; $display("FAIL abort_idle: got %b want 1", req_ready); end
        ref_access(1'b0, 3'd2, 9'h020, 32'h0, mrd, mer);
        issue(1'b0, 3'd2, 9'h020, 32'h0, rd, er, lat, rv_after);
        nvec++; if (rd !== mrd) begin nmis++; $display("FAIL abort_readback: got %h want %h", rd, mrd); end
        // Reset at the same edge as a request: nothing is accepted.
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h020; req_wdata = 32'hBBBBBBBB;
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin @(negedge clk); seen = seen | resp_valid; end
        nvec++; if (seen !== 1'b0) begin nmis++; $display("FAIL reset_req_no_resp: got %b want 0", seen); end
        // Reset during RESP keeps the committed store.
        ref_access(1'b1, 3'd2, 9'h024, 32'h13572468, mrd, mer);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 9'h024; req_wdata = 32'h13572468;
        @(posedge clk); #1 req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = resp_valid; end
        nvec++; if (seen !== 1'b1) begin nmis++; $display("FAIL resp_reset_timeout: got %b want 1", seen); end
        reset = 1'b1;
        @(negedge clk);
        nvec++; if (resp_valid !== 1'b0) begin nmis++; $display("FAIL resp_reset_drop: got %b want 0", resp_valid); end
        reset = 1'b0;
        ref_access(1'b0, 3'd2, 9'h024, 32'h0, mrd, mer);
        issue(1'b0, 3'd2, 9'h024, 32'h0, rd, er, lat, rv_after);
        nvec++; if (rd !== mrd) begin nmis++; $display("FAIL resp_reset_readback: got %h want %h", rd, mrd); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0;
        req_we = 1'b0; req_funct3 = 3'd0; req_addr = 9'h0; req_wdata = 32'h0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_wait0();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
